// File: rtl/accel_pkg.sv
// Shared accelerator definitions: sequencer state encoding and the default
// result / writeback-index widths used by the sequencer and the allocators.
package accel_pkg;

   localparam int DEFAULT_DATA_W = 18;
   localparam int DEFAULT_ADDR_W = 16;

   typedef enum logic [2:0] {
      IDLE    = 3'd0,
      ADVANCE = 3'd1,
      RUN     = 3'd2,
      DRAIN   = 3'd3,
      DONE    = 3'd4
   } seq_state_e;

endpackage

// File: rtl/result_capture.sv
// Sticky capture register for one allocator result: the first value offered
// after a clear is latched and held until the next clear or reset.
module result_capture
   import accel_pkg::*;
#(
   parameter int DATA_W = DEFAULT_DATA_W
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              clear,
   input  logic              cap_en,
   input  logic [DATA_W-1:0] data_in,
   output logic [DATA_W-1:0] res,
   output logic              captured
);

   logic [DATA_W-1:0] res_q, res_d;
   logic              captured_q, captured_d;

   // Latch only the first offer; later offers while captured are ignored
   always_comb begin
      res_d      = res_q;
      captured_d = captured_q;
      if (clear) begin
         res_d      = '0;
         captured_d = 1'b0;
      end else if (cap_en && !captured_q) begin
         res_d      = data_in;
         captured_d = 1'b1;
      end
   end

   // Capture flops, synchronously cleared by reset
   always_ff @(posedge clk) begin
      if (rst) begin
         res_q      <= '0;
         captured_q <= 1'b0;
      end else begin
         res_q      <= res_d;
         captured_q <= captured_d;
      end
   end

   assign res      = res_q;
   assign captured = captured_q;

endmodule

// File: rtl/round_sequencer.sv
// Round sequencer: pulses issue_advance / allocator resets once per round,
// collects one result per allocator, drains them in index order over a
// valid/ready writeback port and signals done after the final round.
module round_sequencer
   import accel_pkg::*;
#(
   parameter int NUM_ALLOC = 4,
   parameter int DATA_W    = DEFAULT_DATA_W,
   parameter int ADDR_W    = DEFAULT_ADDR_W
) (
   input  logic                        clk,
   input  logic                        rst,
   input  logic                        start,
   input  logic                        issue_done,
   input  logic                        filter_done,
   input  logic [NUM_ALLOC-1:0]        alloc_result_ready,
   input  logic [NUM_ALLOC*DATA_W-1:0] alloc_result_data,
   output logic [NUM_ALLOC-1:0]        alloc_rst,
   output logic                        issue_advance,
   output logic                        wb_valid,
   output logic [DATA_W-1:0]           wb_data,
   output logic [ADDR_W-1:0]           wb_addr,
   input  logic                        wb_ready,
   output logic                        busy,
   output logic                        done
);

   localparam int PTR_W = (NUM_ALLOC > 1) ? $clog2(NUM_ALLOC) : 1;
   localparam logic [PTR_W-1:0] LAST_PTR = PTR_W'(NUM_ALLOC - 1);

   seq_state_e state_q, state_d;

   logic [PTR_W-1:0]     ptr_q, ptr_d;
   logic [ADDR_W-1:0]    wb_addr_q, wb_addr_d;
   logic [NUM_ALLOC-1:0] alloc_rst_q, alloc_rst_d;
   logic                 issue_advance_q, issue_advance_d;
   logic                 wb_valid_q, wb_valid_d;
   logic                 busy_q, busy_d;
   logic                 done_q, done_d;

   logic [NUM_ALLOC-1:0] captured;
   logic [NUM_ALLOC-1:0] cap_en;
   logic [DATA_W-1:0]    res [NUM_ALLOC];
   logic                 start_ok;
   logic                 clear_mask;
   logic                 all_captured;
   logic                 accept;
   logic                 last_accept;

   assign start_ok     = start && ((state_q == IDLE) || (state_q == DONE));
   assign clear_mask   = start_ok || (state_q == ADVANCE);
   assign cap_en       = {NUM_ALLOC{state_q == RUN}} & alloc_result_ready;
   assign all_captured = &(captured | cap_en);
   assign accept       = (state_q == DRAIN) && wb_ready;
   assign last_accept  = accept && (ptr_q == LAST_PTR);

   for (genvar g = 0; g < NUM_ALLOC; g++) begin : g_cap
      result_capture #(
         .DATA_W(DATA_W)
      ) u_cap (
         .clk     (clk),
         .rst     (rst),
         .clear   (clear_mask),
         .cap_en  (cap_en[g]),
         .data_in (alloc_result_data[g*DATA_W +: DATA_W]),
         .res     (res[g]),
         .captured(captured[g])
      );
   end

   // State register
   always_ff @(posedge clk) begin
      if (rst) begin
         state_q <= IDLE;
      end else begin
         state_q <= state_d;
      end
   end

   // Next-state: RUN waits for every result regardless of the done flags
   always_comb begin
      state_d = state_q;
      case (state_q)
         IDLE:    if (start) state_d = ADVANCE;
         ADVANCE: state_d = RUN;
         RUN:     if (all_captured) state_d = DRAIN;
         DRAIN:   if (last_accept) state_d = (issue_done && filter_done) ? DONE : ADVANCE;
         DONE:    if (start) state_d = ADVANCE;
         default: state_d = IDLE;
      endcase
   end

   // Output and datapath next values, registered from the upcoming state
   always_comb begin
      ptr_d           = ptr_q;
      wb_addr_d       = wb_addr_q;
      issue_advance_d = (state_d == ADVANCE);
      alloc_rst_d     = {NUM_ALLOC{state_d == ADVANCE}};
      wb_valid_d      = (state_d == DRAIN);
      busy_d          = (state_d != IDLE) && (state_d != DONE);
      done_d          = (state_d == DONE);
      if (start_ok) begin
         wb_addr_d = '0;
         ptr_d     = '0;
      end else if (accept) begin
         wb_addr_d = wb_addr_q + ADDR_W'(1);
         ptr_d     = last_accept ? '0 : ptr_q + PTR_W'(1);
      end
   end

   // Registered outputs, drain pointer and writeback index
   always_ff @(posedge clk) begin
      if (rst) begin
         ptr_q           <= '0;
         wb_addr_q       <= '0;
         alloc_rst_q     <= '0;
         issue_advance_q <= 1'b0;
         wb_valid_q      <= 1'b0;
         busy_q          <= 1'b0;
         done_q          <= 1'b0;
      end else begin
         ptr_q           <= ptr_d;
         wb_addr_q       <= wb_addr_d;
         alloc_rst_q     <= alloc_rst_d;
         issue_advance_q <= issue_advance_d;
         wb_valid_q      <= wb_valid_d;
         busy_q          <= busy_d;
         done_q          <= done_d;
      end
   end

   assign alloc_rst     = alloc_rst_q;
   assign issue_advance = issue_advance_q;
   assign wb_valid      = wb_valid_q;
   assign wb_data       = res[ptr_q];
   assign wb_addr       = wb_addr_q;
   assign busy          = busy_q;
   assign done          = done_q;

endmodule

// File: tb/tb_round_sequencer.sv
// Directed bench for round_sequencer with two allocators.
module tb_round_sequencer;

   localparam int NUM_ALLOC = 2;
   localparam int DATA_W    = 18;
   localparam int ADDR_W    = 16;

   logic                        clk = 1'b0;
   logic                        rst;
   logic                        start;
   logic                        issue_done;
   logic                        filter_done;
   logic [NUM_ALLOC-1:0]        alloc_result_ready;
   logic [NUM_ALLOC*DATA_W-1:0] alloc_result_data;
   logic [NUM_ALLOC-1:0]        alloc_rst;
   logic                        issue_advance;
   logic                        wb_valid;
   logic [DATA_W-1:0]           wb_data;
   logic [ADDR_W-1:0]           wb_addr;
   logic                        wb_ready;
   logic                        busy;
   logic                        done;

   int tests_run    = 0;
   int tests_failed = 0;
   int advance_count;

   round_sequencer #(
      .NUM_ALLOC(NUM_ALLOC),
      .DATA_W   (DATA_W),
      .ADDR_W   (ADDR_W)
   ) dut (
      .clk               (clk),
      .rst               (rst),
      .start             (start),
      .issue_done        (issue_done),
      .filter_done       (filter_done),
      .alloc_result_ready(alloc_result_ready),
      .alloc_result_data (alloc_result_data),
      .alloc_rst         (alloc_rst),
      .issue_advance     (issue_advance),
      .wb_valid          (wb_valid),
      .wb_data           (wb_data),
      .wb_addr           (wb_addr),
      .wb_ready          (wb_ready),
      .busy              (busy),
      .done              (done)
   );

   // Free-running clock
   always #5 clk = ~clk;

   task automatic check_output(input string tag, input logic [31:0] observed,
                               input logic [31:0] expected);
      tests_run++;
      if (observed !== expected) begin
         tests_failed++;
         $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", tag, observed, expected);
      end
   endtask

   // Advance one clock; inputs change and outputs are sampled 1 ns after the edge
   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic offer(input logic [1:0] rdy, input logic [DATA_W-1:0] d0,
                        input logic [DATA_W-1:0] d1);
      alloc_result_ready = rdy;
      alloc_result_data  = {d1, d0};
   endtask

   task automatic check_wb(input string tag, input logic v,
                           input logic [ADDR_W-1:0] a, input logic [DATA_W-1:0] d);
      check_output({tag, "_valid"}, 32'(wb_valid), 32'(v));
      check_output({tag, "_addr"},  32'(wb_addr),  32'(a));
      check_output({tag, "_data"},  32'(wb_data),  32'(d));
   endtask

   initial begin
      rst = 1'b1; start = 1'b0; issue_done = 1'b0; filter_done = 1'b0;
      wb_ready = 1'b0;
      offer(2'b00, '0, '0);
      step(); step();
      rst = 1'b0;

      // Reset state
      check_output("rst_busy", 32'(busy), 32'd0);
      check_output("rst_done", 32'(done), 32'd0);
      check_output("rst_adv",  32'(issue_advance), 32'd0);
      check_output("rst_arst", 32'(alloc_rst), 32'd0);
      check_wb("rst", 1'b0, 16'd0, 18'd0);

      // Simple round start
      start = 1'b1;
      step();
      start = 1'b0;
      check_output("t1_adv",  32'(issue_advance), 32'd1);
      check_output("t1_arst", 32'(alloc_rst), 32'd3);
      check_output("t1_busy", 32'(busy), 32'd1);
      check_output("t1_done", 32'(done), 32'd0);
      step();
      check_output("t1_adv_pulse",  32'(issue_advance), 32'd0);
      check_output("t1_arst_pulse", 32'(alloc_rst), 32'd0);

      // Out-of-order capture
      offer(2'b10, 18'h00000, 18'h00123);
      step();
      offer(2'b00, 18'h01010, 18'h02020);
      check_output("t2_wait", 32'(wb_valid), 32'd0);
      step();
      offer(2'b01, 18'h3FFFF, 18'h02020);
      wb_ready = 1'b1;
      step();
      offer(2'b00, '0, '0);
      check_wb("t2_wb0", 1'b1, 16'd0, 18'h3FFFF);
      step();
      check_wb("t2_wb1", 1'b1, 16'd1, 18'h00123);
      step();
      check_output("t2_next_adv", 32'(issue_advance), 32'd1);
      check_output("t2_addr", 32'(wb_addr), 32'd2);

      // Backpressure and duplicate ready
      wb_ready = 1'b0;
      step();
      offer(2'b01, 18'h0AAAA, '0);
      step();
      offer(2'b01, 18'h15555, '0);
      step();
      offer(2'b10, 18'h15555, 18'h00042);
      step();
      offer(2'b00, '0, '0);
      check_wb("t3_first", 1'b1, 16'd2, 18'h0AAAA);
      for (int i = 0; i < 5; i++) step();
      check_wb("t3_held", 1'b1, 16'd2, 18'h0AAAA);
      wb_ready = 1'b1;
      step();
      check_wb("t3_second", 1'b1, 16'd3, 18'h00042);
      issue_done = 1'b1; filter_done = 1'b1;
      step();
      check_output("t3_done", 32'(done), 32'd1);
      check_output("t3_busy", 32'(busy), 32'd0);
      check_wb("t3_end", 1'b0, 16'd4, wb_data);

      // Multi-round job
      issue_done = 1'b0; filter_done = 1'b0;
      advance_count = 0;
      start = 1'b1;
      step();
      start = 1'b0;
      check_output("t4_addr_clr", 32'(wb_addr), 32'd0);
      check_output("t4_done_clr", 32'(done), 32'd0);
      for (int r = 0; r < 3; r++) begin
         if (issue_advance) advance_count++;
         step();
         offer(2'b11, 18'(r * 16 + 1), 18'(r * 16 + 2));
         step();
         offer(2'b00, '0, '0);
         check_wb($sformatf("t4_r%0d_a", r), 1'b1, 16'(2 * r), 18'(r * 16 + 1));
         if (r == 2) begin
            issue_done = 1'b1; filter_done = 1'b1;
         end
         step();
         check_wb($sformatf("t4_r%0d_b", r), 1'b1, 16'(2 * r + 1), 18'(r * 16 + 2));
         step();
      end
      check_output("t4_adv_count", 32'(advance_count), 32'd3);
      check_output("t4_addr6", 32'(wb_addr), 32'd6);
      check_output("t4_done", 32'(done), 32'd1);

      // Early done flags: RUN must still wait for every result
      start = 1'b1;
      step();
      start = 1'b0;
      step();
      offer(2'b01, 18'h11111, '0);
      step();
      offer(2'b00, '0, '0);
      for (int i = 0; i < 3; i++) step();
      check_output("t5_busy", 32'(busy), 32'd1);
      check_output("t5_done", 32'(done), 32'd0);
      check_output("t5_valid", 32'(wb_valid), 32'd0);
      offer(2'b10, '0, 18'h22222);
      step();
      offer(2'b00, '0, '0);
      check_wb("t5_wb0", 1'b1, 16'd0, 18'h11111);
      step();
      check_wb("t5_wb1", 1'b1, 16'd1, 18'h22222);
      check_output("t5_not_done", 32'(done), 32'd0);
      step();
      check_output("t5_done_end", 32'(done), 32'd1);

      // Reset mid-drain, then restart
      issue_done = 1'b0; filter_done = 1'b0;
      start = 1'b1;
      step();
      start = 1'b0;
      step();
      offer(2'b11, 18'h30303, 18'h04040);
      step();
      offer(2'b00, '0, '0);
      check_wb("t6_wb0", 1'b1, 16'd0, 18'h30303);
      step();
      check_wb("t6_wb1", 1'b1, 16'd1, 18'h04040);
      rst = 1'b1;
      step();
      rst = 1'b0;
      check_wb("t6_rst", 1'b0, 16'd0, 18'd0);
      check_output("t6_rst_busy", 32'(busy), 32'd0);
      check_output("t6_rst_done", 32'(done), 32'd0);
      check_output("t6_rst_adv",  32'(issue_advance), 32'd0);
      check_output("t6_rst_arst", 32'(alloc_rst), 32'd0);
      step();
      check_output("t6_idle_valid", 32'(wb_valid), 32'd0);
      start = 1'b1;
      step();
      check_output("t6_restart_adv", 32'(issue_advance), 32'd1);
      check_output("t6_restart_addr", 32'(wb_addr), 32'd0);
      step();
      step();
      check_output("t6_start_ignored", 32'(issue_advance), 32'd0);
      start = 1'b0;
      offer(2'b11, 18'h00005, 18'h00006);
      step();
      offer(2'b00, '0, '0);
      check_wb("t6_wb_restart", 1'b1, 16'd0, 18'h00005);

      $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
      $finish;
   end

   // Safety bound so the run always terminates
   initial begin
      #100000;
      tests_failed++;
      $display("[TB] FAIL watchdog: got timeout, expected completion");
      $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
      $fatal(1, "[TB] watchdog expired");
   end

endmodule
